piso_bit_serializer: RTL
========================

// Module: piso_bit_serializer
// PURPOSE
//  Parallel-in/serial-out stage feeding the Mealy zero detector's x_in. Accepts a WIDTH-bit word
//  over a valid/ready handshake and shifts it out one bit per enabled clock, with a qualifier.
//  Supports back-to-back words with no idle gap and a stall input for pacing.
// PARAMETERS
//  WIDTH      8     word length in bits, >= 2
//  MSB_FIRST  1     1: bit WIDTH-1 first; 0: bit 0 first
//  IDLE_BIT   1'b0  x_out value whenever no word is being shifted
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low
//  din        in   WIDTH  parallel word, sampled on accept
//  din_valid  in   1      upstream word available
//  din_ready  out  1      stage can accept din this cycle (combinational from state/count/shift_en)
//  shift_en   in   1      1: advance one bit this clock; 0: stall (all state held)
//  x_out      out  1      serial bit (registered) -> detector x_in
//  x_valid    out  1      x_out carries a payload bit (registered)
//  frame_last out  1      x_out is the final bit of the current word (registered)
//  busy       out  1      state == SHIFT
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, shreg=0, cnt=0, x_out=IDLE_BIT, x_valid=0, frame_last=0.
//  Accept: fires at clock edge when din_valid & din_ready; din captured into shreg at that edge.
//  din_ready = shift_en & (state==IDLE | (state==SHIFT & cnt==WIDTH-1)); 0 during reset.
//  States:
//   IDLE : x_out=IDLE_BIT, x_valid=0. On accept -> SHIFT, cnt=0, first bit registered to x_out,
//          x_valid=1 at the same edge (latency: accept edge -> first bit visible next cycle).
//   SHIFT: each edge with shift_en=1: cnt++, next bit to x_out, shreg shifts.
//          cnt==WIDTH-1 (last bit on x_out, frame_last=1): on accept -> stay SHIFT, cnt=0, new
//          word's first bit follows with no gap; no accept -> IDLE, x_out=IDLE_BIT, x_valid=0.
//  Stall: shift_en=0 holds state, cnt, shreg, x_out, x_valid, frame_last; din_ready=0.
//  Bit order: MSB_FIRST=1 shifts left, emits shreg[WIDTH-1]; 0 shifts right, emits shreg[0].
//  Each word: exactly WIDTH x_valid=1 cycles (excluding stall cycles); frame_last on the WIDTH-th.
//  cnt width = $clog2(WIDTH); cnt never exceeds WIDTH-1, no wrap beyond it.
//  din_valid with din_ready=0: ignored, no capture; upstream must hold din stable.
//  Reset mid-word: word discarded, outputs return to reset values immediately (async).
// STRUCTURE
//  Package serial_pkg: state encoding (IDLE=1'b0, SHIFT=1'b1), shared bit-order constants reused
//  by the detector bench and future deserializer.
//  Sub-module ser_bit_counter (WIDTH param): cnt, clear/enable inputs, is_last output.
//  Top: FSM, shift register, output registers, din_ready logic.
// TESTING
//  T1 reset: reset=0 mid-SHIFT -> x_valid=0, x_out=0, busy=0 same cycle; din_ready=1 after release.
//  T2 single word WIDTH=8 MSB_FIRST=1 din=8'b1101_0110, shift_en=1 -> x_out 1,1,0,1,0,1,1,0
//     over 8 cycles from accept+1, frame_last on 8th, then x_out=0, x_valid=0.
//  T3 back-to-back: 8'hA5 then 8'h3C held valid -> 16 contiguous x_valid cycles, din_ready=1 only
//     on idle cycle and 8th bit cycle.
//  T4 stall: shift_en=0 for 3 cycles after bit 3 -> x_out/x_valid frozen, no bit lost/duplicated.
//  T5 MSB_FIRST=0 din=8'h01 -> x_out 1,0,0,0,0,0,0,0.
//  T6 chained with Mealy_Zero_detector: din=8'b1110_0000 -> y_out=1 exactly on cycle of first 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial path: serializer state encoding and bit-order constants
// reused by the detector bench and the future deserializer.
package serial_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   localparam bit SER_MSB_FIRST = 1'b1;
   localparam bit SER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-position counter for the serializer: tracks which bit of the word is on x_out.
module ser_bit_counter #(
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     enable,
   output logic [$clog2(WIDTH)-1:0] cnt,
   output logic                     is_last
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   // Saturates at the last position; the next word restarts it through clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !is_last) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign is_last = (cnt == LAST);

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: accepts a word on valid/ready and emits it one bit per enabled
// clock with a payload qualifier and last-bit marker; back-to-back words run with no gap.
module piso_bit_serializer
   import serial_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = SER_MSB_FIRST,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             shift_en,
   output logic             x_out,
   output logic             x_valid,
   output logic             frame_last,
   output logic             busy
);

   localparam int            CW      = $clog2(WIDTH);
   localparam logic [CW-1:0] PENULT  = CW'(WIDTH - 2);

   ser_state_e       state;
   ser_state_e       next_state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             is_last;
   logic             accept;
   logic             cnt_clear;
   logic             cnt_enable;
   logic             first_bit;
   logic [WIDTH-1:0] din_shifted;
   logic             next_bit;
   logic [WIDTH-1:0] shreg_shifted;

   assign din_ready = reset && shift_en && ((state == IDLE) || is_last);
   assign accept    = din_valid && din_ready;
   assign busy      = (state == SHIFT);

   // The first bit goes straight to x_out on accept, so shreg keeps only the bits still to come.
   assign first_bit     = MSB_FIRST ? din[WIDTH-1] : din[0];
   assign din_shifted   = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
   assign next_bit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
   assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

   assign cnt_clear  = accept;
   assign cnt_enable = shift_en && (state == SHIFT);

   ser_bit_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clock   (clock),
      .reset   (reset),
      .clear   (cnt_clear),
      .enable  (cnt_enable),
      .cnt     (cnt),
      .is_last (is_last)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en && is_last && !accept) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // With shift_en low nothing below changes, which is what makes a stall lossless.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shreg      <= '0;
         x_out      <= IDLE_BIT;
         x_valid    <= 1'b0;
         frame_last <= 1'b0;
      end else if (shift_en) begin
         if (accept) begin
            shreg      <= din_shifted;
            x_out      <= first_bit;
            x_valid    <= 1'b1;
            frame_last <= 1'b0;
         end else if (state == SHIFT) begin
            if (is_last) begin
               shreg      <= '0;
               x_out      <= IDLE_BIT;
               x_valid    <= 1'b0;
               frame_last <= 1'b0;
            end else begin
               shreg      <= shreg_shifted;
               x_out      <= next_bit;
               x_valid    <= 1'b1;
               frame_last <= (cnt == PENULT);
            end
         end
      end
   end

endmodule
